// File: rtl/systolic_ctrl.sv
// Tile sequencer for an NxN weight-stationary PE array: preloads weight rows,
// streams M input vectors, and generates the skewed row/column strobes.
module systolic_ctrl #(
    parameter int N     = 4,
    parameter int LEN_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       num_vecs,
    output logic                   busy,
    output logic                   done,
    output logic                   w_req,
    input  logic                   w_rdy,
    output logic                   w_rd_en,
    output logic [$clog2(N)-1:0]   w_row_idx,
    output logic [N-1:0]           accept_w,
    output logic                   in_rd_en,
    output logic [LEN_W-1:0]       in_idx,
    output logic [N-1:0]           row_valid,
    output logic [N-1:0]           row_switch,
    output logic [N-1:0]           col_valid
);

    localparam int IDX_W = $clog2(N);
    localparam int PH_W  = $clog2(2 * N);

    typedef enum logic [2:0] {IDLE, WREQ, WLOAD, STREAM, DRAIN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] m_reg;
    logic [PH_W-1:0]  phase;
    logic             last_row;
    logic             last_vec;
    logic             first_next;
    logic             stream_next;

    // Values the registered strobes take on the next cycle; they feed the skew chains.
    assign last_row    = (w_row_idx == '0);
    assign last_vec    = (in_idx == m_reg - LEN_W'(1));
    assign first_next  = (state == WLOAD) && last_row;
    assign stream_next = first_next || ((state == STREAM) && !last_vec);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            m_reg      <= '0;
            phase      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            w_req      <= 1'b0;
            w_rd_en    <= 1'b0;
            w_row_idx  <= '0;
            accept_w   <= '0;
            in_rd_en   <= 1'b0;
            in_idx     <= '0;
            row_valid  <= '0;
            row_switch <= '0;
            col_valid  <= '0;
        end else begin
            // Row r sees the stream strobe r cycles late; column c follows the last row by 1+c.
            row_valid  <= {row_valid[N-2:0], stream_next};
            row_switch <= {row_switch[N-2:0], first_next};
            col_valid  <= {col_valid[N-2:0], row_valid[N-1]};
            in_rd_en   <= stream_next;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && (num_vecs != '0)) begin
                        m_reg <= num_vecs;
                        state <= WREQ;
                        busy  <= 1'b1;
                        w_req <= 1'b1;
                    end
                end
                WREQ: begin
                    if (w_rdy) begin
                        state     <= WLOAD;
                        w_req     <= 1'b0;
                        w_rd_en   <= 1'b1;
                        accept_w  <= '1;
                        w_row_idx <= IDX_W'(N - 1);
                    end
                end
                WLOAD: begin
                    if (last_row) begin
                        state    <= STREAM;
                        w_rd_en  <= 1'b0;
                        accept_w <= '0;
                        in_idx   <= '0;
                    end else begin
                        w_row_idx <= w_row_idx - IDX_W'(1);
                    end
                end
                STREAM: begin
                    if (last_vec) begin
                        state  <= DRAIN;
                        phase  <= '0;
                        in_idx <= '0;
                    end else begin
                        in_idx <= in_idx + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    // 2N-1 cycles lets the last vector leave col_valid[N-1].
                    if (phase == PH_W'(2 * N - 2)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
